// File: rtl/fx_regbank.sv
// fx_regbank: per-device fx-bus control/status register bank.
//
// Decodes device-selected fx writes and reads. It holds:
//   - N_CFG read/write config registers with per-register reset values
//   - live status readback for N_STU sensor bytes
//   - sticky rising-edge status with write-1-to-clear
//   - per-byte interrupt masks and a level interrupt
//   - a self-clearing command pulse register
//
// Ports:
//   clk_sys     system clock, rising edge
//   rst         synchronous active-high reset
//   dev_id      device select, compared with address bits [21:16]
//   fx_wr       write strobe (one cycle per write)
//   fx_waddr    write address (bits [15:0] are the register offset)
//   fx_data     write data
//   fx_rd       read strobe (one cycle per read)
//   fx_raddr    read address (bits [15:0] are the register offset)
//   fx_q        registered read data, valid the cycle after fx_rd, else 8'h00
//   stu_sensor  status bytes, byte i in [8i+7:8i], synchronous to clk_sys
//   cfg_out     config register contents, byte i in [8i+7:8i]
//   cmd_pulse   command bits, high for one cycle after a command write
//   irq         registered level interrupt, OR of sticky & mask
module fx_regbank #(
  parameter int                 N_CFG    = 8,
  parameter int                 N_STU    = 2,
  parameter logic [8*N_CFG-1:0] CFG_RST  = '0,
  parameter logic [7:0]         VERSION  = 8'h01,
  parameter logic [15:0]        STU_BASE = 16'h0010,
  parameter logic [15:0]        CMD_ADDR = 16'h0020,
  parameter logic [15:0]        STK_BASE = 16'h0040,
  parameter logic [15:0]        MSK_BASE = 16'h0050,
  parameter logic [15:0]        CFG_BASE = 16'h0080
) (
  input  logic                 clk_sys,
  input  logic                 rst,
  input  logic [5:0]           dev_id,
  input  logic                 fx_wr,
  input  logic [21:0]          fx_waddr,
  input  logic [7:0]           fx_data,
  input  logic                 fx_rd,
  input  logic [21:0]          fx_raddr,
  output logic [7:0]           fx_q,
  input  logic [8*N_STU-1:0]   stu_sensor,
  output logic [8*N_CFG-1:0]   cfg_out,
  output logic [7:0]           cmd_pulse,
  output logic                 irq
);

  // True when offset 'off' addresses instance 'idx' of a block starting at 'base'.
  function automatic logic off_hit(input logic [15:0] off,
                                   input logic [15:0] base,
                                   input logic [15:0] idx);
    logic [15:0] tgt;
    tgt = base + idx;
    return (off == tgt);
  endfunction

  logic [8*N_CFG-1:0] cfg_q,   cfg_d;
  logic [8*N_STU-1:0] msk_q,   msk_d;
  logic [8*N_STU-1:0] stk_q,   stk_d;
  logic [8*N_STU-1:0] prev_q;
  logic [7:0]         cmd_q,   cmd_d;
  logic [7:0]         rdata_q, rdata_d;
  logic               irq_q,   irq_d;

  logic               now_wr;
  logic               now_rd;
  logic [15:0]        woff;
  logic [15:0]        roff;
  logic [8*N_STU-1:0] clr;
  logic [8*N_STU-1:0] rise;
  logic [7:0]         rdata;

  // Write decode, W1C clear mask, sticky edge capture and interrupt next state.
  always_comb begin
    now_wr = fx_wr & (fx_waddr[21:16] == dev_id);
    woff   = fx_waddr[15:0];
    cfg_d  = cfg_q;
    msk_d  = msk_q;
    clr    = '0;
    cmd_d  = 8'h00;
    if (now_wr) begin
      for (int i = 0; i < N_CFG; i++) begin
        cfg_d[8*i +: 8] = off_hit(woff, CFG_BASE, 16'(i)) ? fx_data : cfg_q[8*i +: 8];
      end
      for (int i = 0; i < N_STU; i++) begin
        msk_d[8*i +: 8] = off_hit(woff, MSK_BASE, 16'(i)) ? fx_data : msk_q[8*i +: 8];
        clr[8*i +: 8]   = off_hit(woff, STK_BASE, 16'(i)) ? fx_data : 8'h00;
      end
      if (woff == CMD_ADDR) begin
        cmd_d = fx_data;
      end else begin
        cmd_d = 8'h00;
      end
    end else begin
      cmd_d = 8'h00;
    end
    rise  = stu_sensor & ~prev_q;
    // OR-ing the rise after the clear lets a coincident set beat the W1C.
    stk_d = (stk_q & ~clr) | rise;
    // irq follows the registered sticky bits, so it lags them by one cycle.
    irq_d = |(stk_q & msk_q);
  end

  // Read decode; fx_q returns 8'h00 on any cycle without a selected read.
  always_comb begin
    now_rd = fx_rd & (fx_raddr[21:16] == dev_id);
    roff   = fx_raddr[15:0];
    rdata  = 8'h55;
    if (roff == 16'h0000) begin
      rdata = {2'b00, dev_id};
    end else if (roff == 16'h0001) begin
      rdata = VERSION;
    end else if (roff == CMD_ADDR) begin
      rdata = 8'h00;
    end else begin
      rdata = 8'h55;
    end
    for (int i = 0; i < N_STU; i++) begin
      rdata = off_hit(roff, STU_BASE, 16'(i)) ? stu_sensor[8*i +: 8] : rdata;
      rdata = off_hit(roff, STK_BASE, 16'(i)) ? stk_q[8*i +: 8]      : rdata;
      rdata = off_hit(roff, MSK_BASE, 16'(i)) ? msk_q[8*i +: 8]      : rdata;
    end
    for (int i = 0; i < N_CFG; i++) begin
      rdata = off_hit(roff, CFG_BASE, 16'(i)) ? cfg_q[8*i +: 8] : rdata;
    end
    if (now_rd) begin
      rdata_d = rdata;
    end else begin
      rdata_d = 8'h00;
    end
  end

  // State registers; prev_q tracks the input even in reset so release sees no false edge.
  always_ff @(posedge clk_sys) begin
    prev_q <= stu_sensor;
    if (rst) begin
      cfg_q   <= CFG_RST;
      msk_q   <= '0;
      stk_q   <= '0;
      cmd_q   <= 8'h00;
      rdata_q <= 8'h00;
      irq_q   <= 1'b0;
    end else begin
      cfg_q   <= cfg_d;
      msk_q   <= msk_d;
      stk_q   <= stk_d;
      cmd_q   <= cmd_d;
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
    end
  end

  assign fx_q      = rdata_q;
  assign cfg_out   = cfg_q;
  assign cmd_pulse = cmd_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_fx_regbank.sv
// tb_fx_regbank: directed scoreboard bench for fx_regbank.
// Reads push their expected fx_q into a queue; a negedge monitor pops and
// compares whenever a read result is due, and checks fx_q is 8'h00 otherwise.
module tb_fx_regbank;

  logic        clk_sys;
  logic        rst;
  logic [5:0]  dev_id;
  logic        fx_wr;
  logic [21:0] fx_waddr;
  logic [7:0]  fx_data;
  logic        fx_rd;
  logic [21:0] fx_raddr;
  logic [7:0]  fx_q;
  logic [15:0] stu_sensor;
  logic [63:0] cfg_out;
  logic [7:0]  cmd_pulse;
  logic        irq;

  typedef struct packed {
    logic [21:0] addr;
    logic [7:0]  data;
  } rd_exp_t;

  rd_exp_t     exp_q[$];
  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic        mon_en = 1'b0;
  logic        rd_seen = 1'b0;
  logic [63:0] cfg_exp;

  fx_regbank #(
    .N_CFG   (8),
    .N_STU   (2),
    .CFG_RST (64'h0000_0000_0000_000A)
  ) dut (
    .clk_sys    (clk_sys),
    .rst        (rst),
    .dev_id     (dev_id),
    .fx_wr      (fx_wr),
    .fx_waddr   (fx_waddr),
    .fx_data    (fx_data),
    .fx_rd      (fx_rd),
    .fx_raddr   (fx_raddr),
    .fx_q       (fx_q),
    .stu_sensor (stu_sensor),
    .cfg_out    (cfg_out),
    .cmd_pulse  (cmd_pulse),
    .irq        (irq)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total_cnt++;
    if (act !== req) begin
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end else begin
      pass_cnt++;
    end
  endtask

  // A read result is due on the cycle after fx_rd was sampled.
  always @(posedge clk_sys) rd_seen <= fx_rd;

  always @(negedge clk_sys) begin : monitor
    rd_exp_t e;
    if (mon_en) begin
      if (rd_seen) begin
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL rd_unexpected: read result with no expectation, fx_q=%0h", fx_q);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("rd %06h", e.addr), {56'd0, fx_q}, {56'd0, e.data});
        end
      end else begin
        chk("fx_q idle", {56'd0, fx_q}, 64'd0);
      end
    end
  end

  task automatic cyc();
    @(posedge clk_sys);
    #1;
    fx_wr = 1'b0;
    fx_rd = 1'b0;
  endtask

  task automatic op(input logic wr, input logic [21:0] wa, input logic [7:0] wd,
                    input logic rd, input logic [21:0] ra, input logic [7:0] ex);
    rd_exp_t e;
    fx_wr    = wr;
    fx_waddr = wa;
    fx_data  = wd;
    fx_rd    = rd;
    fx_raddr = ra;
    if (rd) begin
      e.addr = ra;
      e.data = ex;
      exp_q.push_back(e);
    end
    cyc();
  endtask

  task automatic rd(input logic [21:0] a, input logic [7:0] ex);
    op(1'b0, 22'h0, 8'h00, 1'b1, a, ex);
  endtask

  task automatic wr(input logic [21:0] a, input logic [7:0] d);
    op(1'b1, a, d, 1'b0, 22'h0, 8'h00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    dev_id     = 6'h05;
    fx_wr      = 1'b0;
    fx_waddr   = 22'h0;
    fx_data    = 8'h00;
    fx_rd      = 1'b0;
    fx_raddr   = 22'h0;
    stu_sensor = 16'h0000;
    repeat (3) @(posedge clk_sys);
    #1;
    rst = 1'b0;

    // Reset state
    cfg_exp = 64'h0000_0000_0000_000A;
    chk("reset fx_q", {56'd0, fx_q}, 64'd0);
    chk("reset cmd_pulse", {56'd0, cmd_pulse}, 64'd0);
    chk("reset irq", {63'd0, irq}, 64'd0);
    chk("reset cfg_out", cfg_out, cfg_exp);
    mon_en = 1'b1;

    // Reset readback, back-to-back
    rd(22'h05_0000, 8'h05);
    rd(22'h05_0001, 8'h01);
    rd(22'h05_0080, 8'h0A);
    rd(22'h05_0090, 8'h55);

    // Config write and readback
    wr(22'h05_0083, 8'hA5);
    cfg_exp = 64'h0000_0000_A500_000A;
    chk("cfg3 after write", {56'd0, cfg_out[31:24]}, 64'h0A5);
    chk("cfg_out after write", cfg_out, cfg_exp);
    rd(22'h05_0083, 8'hA5);

    // Device mismatch: no write effect, read returns zero
    wr(22'h06_0083, 8'h5A);
    chk("cfg_out after foreign write", cfg_out, cfg_exp);
    rd(22'h06_0083, 8'h00);
    rd(22'h05_0083, 8'hA5);

    // Command pulse
    wr(22'h05_0020, 8'h81);
    chk("cmd_pulse high", {56'd0, cmd_pulse}, 64'h81);
    cyc();
    chk("cmd_pulse cleared", {56'd0, cmd_pulse}, 64'd0);
    rd(22'h05_0020, 8'h00);

    // Offsets past the last instance are unmapped
    wr(22'h05_0088, 8'h77);
    chk("cfg_out after unmapped write", cfg_out, cfg_exp);
    rd(22'h05_0088, 8'h55);
    rd(22'h05_0012, 8'h55);

    // Sticky capture, irq masked off
    stu_sensor = 16'h0004;
    cyc();
    cyc();
    chk("irq masked", {63'd0, irq}, 64'd0);
    rd(22'h05_0040, 8'h04);
    rd(22'h05_0010, 8'h04);
    rd(22'h05_0050, 8'h00);

    // Unmask -> irq
    wr(22'h05_0050, 8'h04);
    cyc();
    chk("irq after mask", {63'd0, irq}, 64'd1);
    rd(22'h05_0050, 8'h04);

    // W1C: irq falls two cycles after the write cycle
    wr(22'h05_0040, 8'h04);
    chk("irq one cycle after W1C", {63'd0, irq}, 64'd1);
    cyc();
    chk("irq two cycles after W1C", {63'd0, irq}, 64'd0);
    rd(22'h05_0040, 8'h00);

    // W1C coincident with a new rising edge: set wins
    stu_sensor = 16'h0000;
    cyc();
    stu_sensor = 16'h0004;
    cyc();
    stu_sensor = 16'h0000;
    cyc();
    rd(22'h05_0040, 8'h04);
    stu_sensor = 16'h0004;
    wr(22'h05_0040, 8'h04);
    rd(22'h05_0040, 8'h04);
    rd(22'h05_0040, 8'h04);
    chk("irq after coincident set/clear", {63'd0, irq}, 64'd1);

    // Second status byte
    stu_sensor = 16'h3004;
    cyc();
    rd(22'h05_0041, 8'h30);
    rd(22'h05_0011, 8'h30);

    // Simultaneous read and write returns the old value
    wr(22'h05_0081, 8'h81);
    op(1'b1, 22'h05_0081, 8'h3C, 1'b1, 22'h05_0081, 8'h81);
    cfg_exp = 64'h0000_0000_A500_3C0A;
    chk("cfg_out after rd/wr", cfg_out, cfg_exp);
    rd(22'h05_0081, 8'h3C);

    // Reset mid-operation drops a pending command
    rst = 1'b1;
    wr(22'h05_0020, 8'hFF);
    rst = 1'b0;
    chk("cmd_pulse dropped in reset", {56'd0, cmd_pulse}, 64'd0);
    chk("cfg_out after mid reset", cfg_out, 64'h0000_0000_0000_000A);
    chk("irq after mid reset", {63'd0, irq}, 64'd0);
    rd(22'h05_0040, 8'h00);
    rd(22'h05_0041, 8'h00);
    rd(22'h05_0050, 8'h00);
    rd(22'h05_0083, 8'h00);
    rd(22'h05_0080, 8'h0A);

    cyc();
    cyc();
    chk("expectation queue drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
